l2_snoop_resp: RTL and testbench
================================

L2_SNOOP_RESP -- requirements
Module: l2_snoop_resp

Interface
REQ-001 SHALL take one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have these snoop inputs: snp_valid  in  1  snooped bus op present; snp_op  in  BUS_OP  snooped operation; snp_addr  in  PA_BITS  snooped physical address; snp_ready  out  1  block idle, can accept.
REQ-003 SHALL have these tag-lookup ports: lk_req  out  1  lookup strobe; lk_index  out  L2_INDEX_LENGTH  set index; lk_tag  out  TYP_TAG  tag; lk_hit  in  1  tag match; lk_way  in  TYP_RU_NUM  matching way; lk_mesi  in  MESI_STATES  state of matching way.
REQ-004 SHALL have these state-update ports: upd_valid  out  1  write MESI state; upd_index  out  L2_INDEX_LENGTH; upd_way  out  TYP_RU_NUM; upd_mesi  out  MESI_STATES  new state.
REQ-005 SHALL have these writeback ports: wb_req  out  1  flush modified line; wb_index  out  L2_INDEX_LENGTH; wb_way  out  TYP_RU_NUM; wb_ack  in  1  flush complete.
REQ-006 SHALL have these response ports: rsp_valid  out  1  one-cycle result strobe; rsp_result  out  SNOOP_RESP  snoop result; proto_err  out  1  one-cycle illegal-state flag.

Function
REQ-010 SHALL run an FSM with states IDLE, LOOKUP, DECIDE, WB_WAIT, RESP; snp_ready=1 only in IDLE.
REQ-011 SHALL accept on snp_valid&&snp_ready in IDLE, register op and address, and go to LOOKUP.
REQ-012 SHALL split address as offset=low $clog2(L2_LINE_SZ) bits, index=next L2_INDEX_LENGTH bits, tag=upper L2_TAG_LENGTH bits.
REQ-013 SHALL assert lk_req for exactly one cycle in LOOKUP; lk_hit/lk_way/lk_mesi are sampled in DECIDE (fixed 1-cycle lookup latency).
REQ-014 SHALL treat a miss (lk_hit=0 or lk_mesi=INV) as NOTHIT with no update and no writeback, for every op.
REQ-015 SHALL apply this table on a hit: READ: MOD->HITM, writeback, SHRD; EXCL->HIT, SHRD; SHRD->HIT, SHRD unchanged (no upd_valid).
REQ-016 SHALL apply for RWIM: MOD->HITM, writeback, INV; EXCL or SHRD->HIT, INV.
REQ-017 SHALL apply for INVALIDATE: SHRD->NOTHIT, INV; MOD or EXCL->NOTHIT, INV, proto_err pulsed in RESP.
REQ-018 SHALL apply for WRITE: any hit->NOTHIT, no state change, proto_err pulsed in RESP if lk_mesi is MOD or EXCL.
REQ-019 SHALL go from DECIDE to WB_WAIT when the result is HITM, otherwise to RESP.
REQ-020 SHALL hold wb_req=1 with stable wb_index/wb_way throughout WB_WAIT and leave WB_WAIT on the cycle after wb_ack=1.
REQ-021 SHALL, in RESP, pulse rsp_valid with rsp_result for exactly one cycle, pulse upd_valid in the same cycle if a state change is required, then return to IDLE.
REQ-022 SHALL have non-HITM latency of 3 cycles: accept at T, lk_req at T+1, decide at T+2, rsp_valid at T+3.
REQ-023 SHALL, for HITM, assert rsp_valid on the cycle after the cycle in which wb_ack is sampled high.
REQ-024 SHALL ignore snp_valid outside IDLE; the bus arbiter holds the op until snp_ready.
REQ-025 SHALL ignore wb_ack outside WB_WAIT.
REQ-026 SHALL have no timeout in WB_WAIT.

Reset
REQ-030 SHALL, while rst_n=0, force the FSM to IDLE and drive snp_ready=1, with every other output at 0: lk_req, upd_valid, wb_req, rsp_valid, proto_err, all index/way/tag fields, upd_mesi=INV, rsp_result=NOTHIT.
REQ-031 SHALL, on reset asserted mid-operation (including WB_WAIT), abandon the op with no rsp_valid and no upd_valid.

Structure
REQ-040 SHALL add to the shared package: the SNP_FSM enum, L2_OFFSET_LENGTH=$clog2(L2_LINE_SZ), and a SNP_ACTION struct {SNOOP_RESP result; logic upd; MESI_STATES nxt; logic wb; logic err}.
REQ-041 SHALL place the REQ-014..018 table in one combinational sub-module l2_snoop_decode (inputs op, hit, mesi; output SNP_ACTION); the FSM and registers stay in l2_snoop_resp.

Verification
REQ-050 SHALL cover: READ 0x0000_1040, lk_hit=1, lk_mesi=EXCL -> rsp_valid at T+3 with HIT, upd_valid with upd_mesi=SHRD, wb_req never asserted.
REQ-051 SHALL cover: RWIM, lk_mesi=MOD, wb_ack after 5 cycles -> wb_req held 5 cycles, then HITM with upd_mesi=INV on the cycle after wb_ack.
REQ-052 SHALL cover: READ with lk_hit=0 -> NOTHIT at T+3, upd_valid=0, wb_req=0.
REQ-053 SHALL cover: INVALIDATE, lk_mesi=EXCL -> NOTHIT, upd_mesi=INV, proto_err=1 for one cycle.
REQ-054 SHALL cover: snp_valid held through a busy op -> second op accepted only on the first cycle snp_ready=1, and responses stay in order.
REQ-055 SHALL cover: rst_n low during WB_WAIT -> outputs match REQ-030 immediately, and no rsp_valid follows.

Source files
------------

// File: rtl/l2_snoop_resp_pkg.sv
// Shared L2 types: bus ops, MESI states, snoop results, address geometry and
// the snoop responder's FSM encoding and per-snoop action record.
package l2_snoop_resp_pkg;

    // Physical address geometry
    localparam int PA_BITS          = 32;
    localparam int L2_LINE_SZ       = 64;
    localparam int L2_OFFSET_LENGTH = $clog2(L2_LINE_SZ);
    localparam int L2_INDEX_LENGTH  = 10;
    localparam int L2_TAG_LENGTH    = PA_BITS - L2_INDEX_LENGTH - L2_OFFSET_LENGTH;
    localparam int L2_WAYS          = 8;
    localparam int L2_WAY_BITS      = $clog2(L2_WAYS);

    typedef logic [L2_TAG_LENGTH-1:0]   TYP_TAG;
    typedef logic [L2_INDEX_LENGTH-1:0] TYP_INDEX;
    typedef logic [L2_WAY_BITS-1:0]     TYP_RU_NUM;
    typedef logic [PA_BITS-1:0]         TYP_PA;

    typedef enum logic [1:0] {
        INV  = 2'd0,
        SHRD = 2'd1,
        EXCL = 2'd2,
        MOD  = 2'd3
    } MESI_STATES;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        RWIM       = 2'd2,
        INVALIDATE = 2'd3
    } BUS_OP;

    typedef enum logic [1:0] {
        NOTHIT = 2'd0,
        HIT    = 2'd1,
        HITM   = 2'd2
    } SNOOP_RESP;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        DECIDE  = 3'd2,
        WB_WAIT = 3'd3,
        RESP    = 3'd4
    } SNP_FSM;

    // Everything the responder has to do for one snoop, decided in one shot
    typedef struct packed {
        SNOOP_RESP  result;  // answer driven on the bus
        logic       upd;     // MESI state of the hit way must be rewritten
        MESI_STATES nxt;     // new state when upd is set
        logic       wb;      // modified line must be flushed first
        logic       err;     // snoop hit a state that this op cannot legally see
    } SNP_ACTION;

    localparam SNP_ACTION SNP_ACT_NONE = '{
        result: NOTHIT,
        upd:    1'b0,
        nxt:    INV,
        wb:     1'b0,
        err:    1'b0
    };

    // Set index of a physical address
    function automatic TYP_INDEX pa_index(input TYP_PA a);
        return a[L2_OFFSET_LENGTH +: L2_INDEX_LENGTH];
    endfunction

    // Tag of a physical address
    function automatic TYP_TAG pa_tag(input TYP_PA a);
        return a[PA_BITS-1 -: L2_TAG_LENGTH];
    endfunction

endpackage

// File: rtl/l2_snoop_resp_if.sv
// Snoop responder bus bundle: snooped op in, tag lookup, MESI update,
// writeback handshake and snoop result. "slave" is the responder's view,
// "master" the view of the surrounding cache / bus logic.
interface l2_snoop_resp_if;
    import l2_snoop_resp_pkg::*;

    // snooped bus operation
    logic       snp_valid;
    BUS_OP      snp_op;
    TYP_PA      snp_addr;
    logic       snp_ready;

    // tag lookup (one-cycle latency)
    logic       lk_req;
    TYP_INDEX   lk_index;
    TYP_TAG     lk_tag;
    logic       lk_hit;
    TYP_RU_NUM  lk_way;
    MESI_STATES lk_mesi;

    // MESI state write
    logic       upd_valid;
    TYP_INDEX   upd_index;
    TYP_RU_NUM  upd_way;
    MESI_STATES upd_mesi;

    // modified-line flush
    logic       wb_req;
    TYP_INDEX   wb_index;
    TYP_RU_NUM  wb_way;
    logic       wb_ack;

    // snoop result
    logic       rsp_valid;
    SNOOP_RESP  rsp_result;
    logic       proto_err;

    modport slave (
        input  snp_valid, snp_op, snp_addr,
        output snp_ready,
        output lk_req, lk_index, lk_tag,
        input  lk_hit, lk_way, lk_mesi,
        output upd_valid, upd_index, upd_way, upd_mesi,
        output wb_req, wb_index, wb_way,
        input  wb_ack,
        output rsp_valid, rsp_result, proto_err
    );

    modport master (
        output snp_valid, snp_op, snp_addr,
        input  snp_ready,
        input  lk_req, lk_index, lk_tag,
        output lk_hit, lk_way, lk_mesi,
        input  upd_valid, upd_index, upd_way, upd_mesi,
        input  wb_req, wb_index, wb_way,
        output wb_ack,
        input  rsp_valid, rsp_result, proto_err
    );

endinterface

// File: rtl/l2_snoop_resp_decode.sv
// Snoop action table: maps (op, lookup hit, MESI state of the hit way) to the
// bus result, state update, writeback need and protocol-error flag.
// Purely combinational.
module l2_snoop_decode
    import l2_snoop_resp_pkg::*;
(
    input  BUS_OP      i_op,
    input  logic       i_hit,
    input  MESI_STATES i_mesi,
    output SNP_ACTION  o_act
);

    // A tag match on an invalid way is not a hit
    logic w_valid_hit;
    assign w_valid_hit = i_hit && (i_mesi != INV);

    // Action table; anything not listed is a plain miss with no side effects
    always_comb begin
        o_act = SNP_ACT_NONE;
        if (w_valid_hit) begin
            unique case (i_op)
                READ: begin
                    // Another reader: owner degrades to shared
                    if (i_mesi == MOD) begin
                        o_act.result = HITM;
                        o_act.wb     = 1'b1;
                        o_act.upd    = 1'b1;
                        o_act.nxt    = SHRD;
                    end else if (i_mesi == EXCL) begin
                        o_act.result = HIT;
                        o_act.upd    = 1'b1;
                        o_act.nxt    = SHRD;
                    end else begin
                        // already shared: nothing to write
                        o_act.result = HIT;
                    end
                end
                RWIM: begin
                    // Reader intends to modify: our copy must go away
                    o_act.result = (i_mesi == MOD) ? HITM : HIT;
                    o_act.wb     = (i_mesi == MOD);
                    o_act.upd    = 1'b1;
                    o_act.nxt    = INV;
                end
                INVALIDATE: begin
                    // Only a shared copy can legally be invalidated silently
                    o_act.result = NOTHIT;
                    o_act.upd    = 1'b1;
                    o_act.nxt    = INV;
                    o_act.err    = (i_mesi == MOD) || (i_mesi == EXCL);
                end
                WRITE: begin
                    // Someone else writes a line we own: protocol violation
                    o_act.result = NOTHIT;
                    o_act.err    = (i_mesi == MOD) || (i_mesi == EXCL);
                end
                default: begin
                    o_act = SNP_ACT_NONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/l2_snoop_resp.sv
// L2 snoop responder: accepts one snooped bus op at a time, looks its tag up,
// flushes a modified line when needed, then reports the snoop result and
// rewrites the MESI state of the hit way.
module l2_snoop_resp
    import l2_snoop_resp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    l2_snoop_resp_if.slave  bus
);

    SNP_FSM    r_state;
    SNP_FSM    w_state_next;

    BUS_OP     r_op;
    TYP_INDEX  r_index;
    TYP_TAG    r_tag;
    SNP_ACTION r_act;
    TYP_RU_NUM r_way;

    SNP_ACTION w_act;
    logic      w_accept;

    assign w_accept = (r_state == IDLE) && bus.snp_valid;

    // Table lookup on the live lookup result; only consumed in DECIDE
    l2_snoop_decode u_decode (
        .i_op   (r_op),
        .i_hit  (bus.lk_hit),
        .i_mesi (bus.lk_mesi),
        .o_act  (w_act)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the snooped op and split its address when it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= READ;
            r_index <= '0;
            r_tag   <= '0;
        end else if (w_accept) begin
            r_op    <= bus.snp_op;
            r_index <= pa_index(bus.snp_addr);
            r_tag   <= pa_tag(bus.snp_addr);
        end
    end

    // Freeze the decided action and hit way so WB_WAIT/RESP see stable values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act <= SNP_ACT_NONE;
            r_way <= '0;
        end else if (r_state == DECIDE) begin
            r_act <= w_act;
            r_way <= bus.lk_way;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.snp_valid) begin
                    w_state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                w_state_next = DECIDE;
            end
            DECIDE: begin
                // a modified hit must be flushed before answering
                w_state_next = (w_act.result == HITM) ? WB_WAIT : RESP;
            end
            WB_WAIT: begin
                // no timeout: the flush always completes eventually
                if (bus.wb_ack) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output decode: idle values first, then per-state strobes
    always_comb begin
        bus.snp_ready  = 1'b0;
        bus.lk_req     = 1'b0;
        bus.upd_valid  = 1'b0;
        bus.upd_mesi   = INV;
        bus.wb_req     = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_result = NOTHIT;
        bus.proto_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.snp_ready = 1'b1;
            end
            LOOKUP: begin
                bus.lk_req = 1'b1;
            end
            WB_WAIT: begin
                bus.wb_req = 1'b1;
            end
            RESP: begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_result = r_act.result;
                bus.proto_err  = r_act.err;
                bus.upd_valid  = r_act.upd;
                bus.upd_mesi   = r_act.upd ? r_act.nxt : INV;
            end
            default: begin
                bus.snp_ready = 1'b0;
            end
        endcase
    end

    // Address and way fields come straight from the registers (zero in reset)
    assign bus.lk_index  = r_index;
    assign bus.lk_tag    = r_tag;
    assign bus.upd_index = r_index;
    assign bus.upd_way   = r_way;
    assign bus.wb_index  = r_index;
    assign bus.wb_way    = r_way;

endmodule

// File: tb/tb_l2_snoop_resp.sv
// Directed bench for l2_snoop_resp: expected responses are queued when a
// snoop is driven and compared when the responder strobes rsp_valid.
module tb_l2_snoop_resp;
    import l2_snoop_resp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l2_snoop_resp_if bus_if ();

    l2_snoop_resp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        string      name;
        BUS_OP      op;
        TYP_PA      addr;
        logic       hit;
        TYP_RU_NUM  way;
        MESI_STATES mesi;
        int         ack_dly;
        SNOOP_RESP  res;
        logic       upd;
        MESI_STATES nxt;
        logic       err;
    } txn_t;

    txn_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   n_txn     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t mk(input string name, input BUS_OP op, input TYP_PA addr,
                                input logic hit, input TYP_RU_NUM way, input MESI_STATES mesi,
                                input int ack_dly, input SNOOP_RESP res, input logic upd,
                                input MESI_STATES nxt, input logic err);
        txn_t t;
        t.name = name; t.op = op; t.addr = addr; t.hit = hit; t.way = way;
        t.mesi = mesi; t.ack_dly = ack_dly; t.res = res; t.upd = upd;
        t.nxt = nxt; t.err = err;
        return t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_snp_ready"},  64'(bus_if.snp_ready),  64'(1));
        chk({tag, "_lk_req"},     64'(bus_if.lk_req),     64'(0));
        chk({tag, "_lk_index"},   64'(bus_if.lk_index),   64'(0));
        chk({tag, "_lk_tag"},     64'(bus_if.lk_tag),     64'(0));
        chk({tag, "_upd_valid"},  64'(bus_if.upd_valid),  64'(0));
        chk({tag, "_upd_index"},  64'(bus_if.upd_index),  64'(0));
        chk({tag, "_upd_way"},    64'(bus_if.upd_way),    64'(0));
        chk({tag, "_upd_mesi"},   64'(bus_if.upd_mesi),   64'(INV));
        chk({tag, "_wb_req"},     64'(bus_if.wb_req),     64'(0));
        chk({tag, "_wb_index"},   64'(bus_if.wb_index),   64'(0));
        chk({tag, "_wb_way"},     64'(bus_if.wb_way),     64'(0));
        chk({tag, "_rsp_valid"},  64'(bus_if.rsp_valid),  64'(0));
        chk({tag, "_rsp_result"}, 64'(bus_if.rsp_result), 64'(NOTHIT));
        chk({tag, "_proto_err"},  64'(bus_if.proto_err),  64'(0));
    endtask

    // Present a snoop in IDLE, queue its expectation, step to LOOKUP
    task automatic accept(input txn_t t, input bit hold);
        chk({t.name, "_ready"}, 64'(bus_if.snp_ready), 64'(1));
        bus_if.snp_valid = 1'b1;
        bus_if.snp_op    = t.op;
        bus_if.snp_addr  = t.addr;
        sb.push_back(t);
        tick();
        if (!hold) bus_if.snp_valid = 1'b0;
    endtask

    // Called in the LOOKUP cycle of the oldest queued snoop; runs it to RESP,
    // checks the response and steps one cycle back to IDLE
    task automatic service();
        txn_t t;
        txn_t e;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() == 0) return;
        t = sb[0];
        // LOOKUP (T+1)
        chk({t.name, "_lk_req"},   64'(bus_if.lk_req),   64'(1));
        chk({t.name, "_lk_index"}, 64'(bus_if.lk_index), 64'(t.addr[15:6]));
        chk({t.name, "_lk_tag"},   64'(bus_if.lk_tag),   64'(t.addr[31:16]));
        chk({t.name, "_busy"},     64'(bus_if.snp_ready), 64'(0));
        bus_if.lk_hit  = t.hit;
        bus_if.lk_way  = t.way;
        bus_if.lk_mesi = t.mesi;
        tick();
        // DECIDE (T+2)
        chk({t.name, "_lk_req_1cyc"}, 64'(bus_if.lk_req),    64'(0));
        chk({t.name, "_no_rsp_dec"},  64'(bus_if.rsp_valid), 64'(0));
        tick();
        if (t.res == HITM) begin
            for (int i = 0; i < t.ack_dly; i++) begin
                chk({t.name, "_wb_req"},    64'(bus_if.wb_req),    64'(1));
                chk({t.name, "_wb_index"},  64'(bus_if.wb_index),  64'(t.addr[15:6]));
                chk({t.name, "_wb_way"},    64'(bus_if.wb_way),    64'(t.way));
                chk({t.name, "_no_rsp_wb"}, 64'(bus_if.rsp_valid), 64'(0));
                if (i == t.ack_dly - 1) bus_if.wb_ack = 1'b1;
                tick();
                bus_if.wb_ack = 1'b0;
            end
        end
        // RESP
        chk({t.name, "_rsp_valid"}, 64'(bus_if.rsp_valid), 64'(1));
        chk({t.name, "_wb_req_off"}, 64'(bus_if.wb_req),   64'(0));
        if (bus_if.rsp_valid === 1'b1) begin
            e = sb.pop_front();
            chk({e.name, "_result"},    64'(bus_if.rsp_result), 64'(e.res));
            chk({e.name, "_upd_valid"}, 64'(bus_if.upd_valid),  64'(e.upd));
            if (e.upd) begin
                chk({e.name, "_upd_mesi"},  64'(bus_if.upd_mesi),  64'(e.nxt));
                chk({e.name, "_upd_index"}, 64'(bus_if.upd_index), 64'(e.addr[15:6]));
                chk({e.name, "_upd_way"},   64'(bus_if.upd_way),   64'(e.way));
            end
            chk({e.name, "_proto_err"}, 64'(bus_if.proto_err), 64'(e.err));
            n_txn++;
            $display("[%0t] txn %0d %s: result=%s upd=%0d mesi=%s err=%0d", $time, n_txn,
                     e.name, bus_if.rsp_result.name(), bus_if.upd_valid,
                     bus_if.upd_mesi.name(), bus_if.proto_err);
        end
        bus_if.lk_hit  = 1'b0;
        bus_if.lk_way  = '0;
        bus_if.lk_mesi = INV;
        tick();
        chk({t.name, "_rsp_1cyc"}, 64'(bus_if.rsp_valid), 64'(0));
        chk({t.name, "_upd_1cyc"}, 64'(bus_if.upd_valid), 64'(0));
        chk({t.name, "_err_1cyc"}, 64'(bus_if.proto_err), 64'(0));
        chk({t.name, "_idle"},     64'(bus_if.snp_ready), 64'(1));
    endtask

    task automatic run(input txn_t t);
        accept(t, 1'b0);
        service();
    endtask

    initial begin
        txn_t a;
        txn_t b;
        rst_n            = 1'b0;
        bus_if.snp_valid = 1'b0;
        bus_if.snp_op    = READ;
        bus_if.snp_addr  = '0;
        bus_if.lk_hit    = 1'b0;
        bus_if.lk_way    = '0;
        bus_if.lk_mesi   = INV;
        bus_if.wb_ack    = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Main table, one step per line
        run(mk("read_excl",   READ,       32'h0000_1040, 1'b1, 3'd3, EXCL, 0, HIT,    1'b1, SHRD, 1'b0));
        run(mk("rwim_mod",    RWIM,       32'h0ABC_D380, 1'b1, 3'd5, MOD,  5, HITM,   1'b1, INV,  1'b0));
        run(mk("read_miss",   READ,       32'h1234_5678, 1'b0, 3'd2, MOD,  0, NOTHIT, 1'b0, INV,  1'b0));
        run(mk("inv_excl",    INVALIDATE, 32'h0000_2FC0, 1'b1, 3'd1, EXCL, 0, NOTHIT, 1'b1, INV,  1'b1));
        run(mk("read_mod",    READ,       32'hFFFF_FFC0, 1'b1, 3'd7, MOD,  1, HITM,   1'b1, SHRD, 1'b0));
        run(mk("read_shrd",   READ,       32'h0000_0040, 1'b1, 3'd6, SHRD, 0, HIT,    1'b0, INV,  1'b0));
        run(mk("rwim_shrd",   RWIM,       32'h8000_0100, 1'b1, 3'd4, SHRD, 0, HIT,    1'b1, INV,  1'b0));
        run(mk("rwim_excl",   RWIM,       32'h4000_0A00, 1'b1, 3'd2, EXCL, 0, HIT,    1'b1, INV,  1'b0));
        run(mk("write_mod",   WRITE,      32'h0001_0200, 1'b1, 3'd1, MOD,  0, NOTHIT, 1'b0, INV,  1'b1));
        run(mk("write_shrd",  WRITE,      32'h0002_0300, 1'b1, 3'd0, SHRD, 0, NOTHIT, 1'b0, INV,  1'b0));
        run(mk("inv_shrd",    INVALIDATE, 32'h0003_0400, 1'b1, 3'd3, SHRD, 0, NOTHIT, 1'b1, INV,  1'b0));
        run(mk("inv_mod",     INVALIDATE, 32'h0004_0500, 1'b1, 3'd5, MOD,  0, NOTHIT, 1'b1, INV,  1'b1));
        run(mk("hit_inv_way", RWIM,       32'h0005_0600, 1'b1, 3'd2, INV,  0, NOTHIT, 1'b0, INV,  1'b0));

        // Back-to-back: second op held on the bus while the first is busy
        a = mk("b2b_first",  RWIM, 32'h0006_07C0, 1'b1, 3'd6, MOD,  2, HITM, 1'b1, INV, 1'b0);
        b = mk("b2b_second", READ, 32'h0007_0880, 1'b1, 3'd1, SHRD, 0, HIT,  1'b0, INV, 1'b0);
        accept(a, 1'b1);
        bus_if.snp_op   = b.op;
        bus_if.snp_addr = b.addr;
        sb.push_back(b);
        service();
        tick();
        bus_if.snp_valid = 1'b0;
        service();

        // Stray flush acknowledge while idle must not shorten a later flush
        bus_if.wb_ack = 1'b1;
        tick();
        bus_if.wb_ack = 1'b0;
        chk("stray_ack_no_wb", 64'(bus_if.wb_req), 64'(0));
        run(mk("read_mod_ack3", READ, 32'h0008_0940, 1'b1, 3'd2, MOD, 3, HITM, 1'b1, SHRD, 1'b0));

        // Reset in the middle of a flush: abandon without any response
        bus_if.snp_valid = 1'b1;
        bus_if.snp_op    = RWIM;
        bus_if.snp_addr  = 32'h0009_0A40;
        tick();
        bus_if.snp_valid = 1'b0;
        bus_if.lk_hit    = 1'b1;
        bus_if.lk_way    = 3'd4;
        bus_if.lk_mesi   = MOD;
        tick();
        tick();
        chk("rst_mid_wb_req", 64'(bus_if.wb_req), 64'(1));
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        bus_if.lk_hit  = 1'b0;
        bus_if.lk_way  = '0;
        bus_if.lk_mesi = INV;
        bus_if.wb_ack  = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_no_rsp", 64'(bus_if.rsp_valid), 64'(0));
            chk("post_rst_no_upd", 64'(bus_if.upd_valid), 64'(0));
            chk("post_rst_no_wb",  64'(bus_if.wb_req),    64'(0));
            tick();
            bus_if.wb_ack = 1'b0;
        end
        run(mk("after_rst", READ, 32'h000A_0B00, 1'b1, 3'd7, EXCL, 0, HIT, 1'b1, SHRD, 1'b0));

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
